// File: rtl/kolibri_pkg.sv
// Shared definitions for the Kolibri SD-card SPI master: register indices,
// register bit positions and the shift-engine state encoding.
package kolibri_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_SEL0 = 0;
    localparam int CTRL_SEL1 = 1;
    localparam int CTRL_IE   = 7;

    localparam int STAT_BUSY = 7;
    localparam int STAT_DONE = 6;
    localparam int STAT_OVR  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } spi_state_t;

endpackage

// File: rtl/kolibri_spi_if.sv
// Pin bundle of the SPI master: 6309 bus window on one side, SD-card slots on the other.
// The slave modport is the SPI block itself; master is whoever drives the bus and the card.
interface kolibri_spi_if;

    logic       nE;
    logic       nSPICS;
    logic       RW;
    logic [1:0] A;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic       D_OE;
    logic       MISO;
    logic       MOSI;
    logic       SCLK;
    logic       nSD0;
    logic       nSD1;
    logic       nIRQ;

    modport slave (
        input  nE, nSPICS, RW, A, D_IN, MISO,
        output D_OUT, D_OE, MOSI, SCLK, nSD0, nSD1, nIRQ
    );

    modport master (
        output nE, nSPICS, RW, A, D_IN, MISO,
        input  D_OUT, D_OE, MOSI, SCLK, nSD0, nSD1, nIRQ
    );

endinterface

// File: rtl/kolibri_bus_sync.sv
// Brings the asynchronous 6309 bus into the 48 MHz domain and emits one
// write or read strobe per bus cycle, on the synchronised rising edge of nE.
module kolibri_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ne,
    input  logic       nspics,
    input  logic       rw,
    input  logic [1:0] a,
    input  logic [7:0] d_in,
    output logic       wr_stb,
    output logic       rd_stb,
    output logic [1:0] a_lat,
    output logic [7:0] d_lat
);

    logic [SYNC_STAGES-1:0] ne_sync_q, ne_sync_d;
    logic                   ne_prev_q, ne_prev_d;
    logic                   cs_q, cs_d;
    logic                   rw_q, rw_d;
    logic [1:0]             a_q, a_d;
    logic [7:0]             din_q, din_d;
    logic                   ne_rise;

    always_comb begin
        ne_sync_d    = ne_sync_q << 1;
        ne_sync_d[0] = ne;
        ne_prev_d    = ne_sync_q[SYNC_STAGES-1];
        cs_d         = nspics;
        rw_d         = rw;
        a_d          = a;
        din_d        = d_in;
    end

    // Idle bus is nE high, so the chain resets high to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ne_sync_q <= '1;
            ne_prev_q <= 1'b1;
            cs_q      <= 1'b1;
            rw_q      <= 1'b1;
            a_q       <= 2'd0;
            din_q     <= 8'h00;
        end else begin
            ne_sync_q <= ne_sync_d;
            ne_prev_q <= ne_prev_d;
            cs_q      <= cs_d;
            rw_q      <= rw_d;
            a_q       <= a_d;
            din_q     <= din_d;
        end
    end

    assign ne_rise = ne_sync_q[SYNC_STAGES-1] & ~ne_prev_q;
    assign wr_stb  = ne_rise & ~cs_q & ~rw_q;
    assign rd_stb  = ne_rise & ~cs_q &  rw_q;
    assign a_lat   = a_q;
    assign d_lat   = din_q;

endmodule

// File: rtl/kolibri_spi.sv
// SPI master (mode 0, MSB first) for the two SD-card slots behind $FE20-$FE23.
// Define KOLIBRI_SPI_IRQ_EN to build the CTRL.IE bit and the registered nIRQ output.
module kolibri_spi
    import kolibri_pkg::*;
#(
    parameter int DIV_RST     = 59,
    parameter int SYNC_STAGES = 2
) (
    input  logic         MHZ48,
    input  logic         RES,
    kolibri_spi_if.slave bus
);

    logic       wr_stb, rd_stb;
    logic [1:0] a_lat;
    logic [7:0] d_lat;

    spi_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] div_q, div_d;
    logic [7:0] wdiv_q, wdiv_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       sel0_q, sel0_d;
    logic       sel1_q, sel1_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;
    logic       busy;
    logic       ie;
    logic [7:0] d_out;

`ifdef KOLIBRI_SPI_IRQ_EN
    logic ie_q, ie_d;
    logic nirq_q, nirq_d;
    assign ie = ie_q;
`else
    assign ie = 1'b0;
`endif

    kolibri_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk    (MHZ48),
        .rst    (RES),
        .ne     (bus.nE),
        .nspics (bus.nSPICS),
        .rw     (bus.RW),
        .a      (bus.A),
        .d_in   (bus.D_IN),
        .wr_stb (wr_stb),
        .rd_stb (rd_stb),
        .a_lat  (a_lat),
        .d_lat  (d_lat)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        div_d     = div_q;
        wdiv_d    = wdiv_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        sel0_d    = sel0_q;
        sel1_d    = sel1_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
`ifdef KOLIBRI_SPI_IRQ_EN
        ie_d      = ie_q;
        nirq_d    = ~(ie_q & done_q);
`endif

        if (wr_stb) begin
            case (a_lat)
                REG_DATA: begin
                    if (state_q == IDLE) begin
                        shift_d   = d_lat;
                        wdiv_d    = div_q;
                        div_cnt_d = div_q;
                        bit_cnt_d = 3'd7;
                        mosi_d    = d_lat[7];
                        sclk_d    = 1'b0;
                        done_d    = 1'b0;
                        state_d   = LO;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                REG_CTRL: begin
                    sel0_d = d_lat[CTRL_SEL0];
                    sel1_d = d_lat[CTRL_SEL1];
`ifdef KOLIBRI_SPI_IRQ_EN
                    ie_d   = d_lat[CTRL_IE];
`endif
                end
                REG_DIV:  div_d = d_lat;
                default: ;
            endcase
        end

        if (rd_stb && (a_lat == REG_DATA)) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end

        // Evaluated after the bus so that a completing transfer wins over a DATA-read clear.
        case (state_q)
            IDLE: ;
            LO: begin
                if (div_cnt_q == 8'd0) begin
                    sclk_d    = 1'b1;
                    shift_d   = {shift_q[6:0], bus.MISO};
                    div_cnt_d = wdiv_q;
                    state_d   = HI;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
            HI: begin
                if (div_cnt_q == 8'd0) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = wdiv_q;
                    if (bit_cnt_q == 3'd0) begin
                        rx_d    = shift_q;
                        mosi_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        mosi_d    = shift_q[7];
                        state_d   = LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            rx_q      <= 8'hFF;
            div_q     <= 8'(DIV_RST);
            wdiv_q    <= 8'(DIV_RST);
            div_cnt_q <= 8'h00;
            bit_cnt_q <= 3'd0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            sel0_q    <= 1'b0;
            sel1_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef KOLIBRI_SPI_IRQ_EN
            ie_q      <= 1'b0;
            nirq_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            div_q     <= div_d;
            wdiv_q    <= wdiv_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            sel0_q    <= sel0_d;
            sel1_q    <= sel1_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
`ifdef KOLIBRI_SPI_IRQ_EN
            ie_q      <= ie_d;
            nirq_q    <= nirq_d;
`endif
        end
    end

    always_comb begin
        d_out = 8'h00;
        case (bus.A)
            REG_DATA: d_out = rx_q;
            REG_CTRL: begin
                d_out[CTRL_SEL0] = sel0_q;
                d_out[CTRL_SEL1] = sel1_q;
                d_out[CTRL_IE]   = ie;
            end
            REG_DIV:  d_out = div_q;
            REG_STATUS: begin
                d_out[STAT_BUSY] = busy;
                d_out[STAT_DONE] = done_q;
                d_out[STAT_OVR]  = ovr_q;
            end
            default: d_out = 8'h00;
        endcase
    end

    // SEL0 masks SEL1 so two cards can never drive MISO together.
    assign bus.D_OUT = d_out;
    assign bus.D_OE  = ~bus.nSPICS & bus.RW & ~bus.nE;
    assign bus.SCLK  = sclk_q;
    assign bus.MOSI  = mosi_q;
    assign bus.nSD0  = ~sel0_q;
    assign bus.nSD1  = ~(sel1_q & ~sel0_q);
`ifdef KOLIBRI_SPI_IRQ_EN
    assign bus.nIRQ  = nirq_q;
`else
    assign bus.nIRQ  = 1'b1;
`endif

endmodule

// File: tb/tb_kolibri_spi.sv
// Scoreboard bench for kolibri_spi: stimulus pushes expected register reads, pin
// snapshots and SCLK timing figures; a negedge monitor pops and compares them.
module tb_kolibri_spi;
    import kolibri_pkg::*;

    localparam int K_READ  = 0;
    localparam int K_PIN   = 1;
    localparam int K_MEAS  = 2;
    localparam int K_DRAIN = 3;
    localparam int SYNC    = 2;

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } item_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    kolibri_spi_if ifc ();

    kolibri_spi #(
        .DIV_RST     (59),
        .SYNC_STAGES (SYNC)
    ) dut (
        .MHZ48 (clk),
        .RES   (res),
        .bus   (ifc)
    );

    logic loopback = 1'b0;
    logic miso_val = 1'b0;
    assign ifc.MISO = loopback ? ifc.MOSI : miso_val;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    item_t exp_q[$];
    int    errors    = 0;
    int    checks    = 0;
    bit    pin_req   = 1'b0;
    bit    meas_req  = 1'b0;
    bit    drain_req = 1'b0;
    int    meas_val  = 0;
    bit    oe_prev   = 1'b0;

    function automatic int pins_now();
        return {26'd0, ifc.SCLK, ifc.MOSI, ifc.nSD0, ifc.nSD1, ifc.nIRQ, ifc.D_OE};
    endfunction

    task automatic scoreboard(input int kind, input int act);
        item_t e;
        if (exp_q.size() == 0) begin
            checks <= checks + 1;
            errors <= errors + 1;
            $display("[TB] FAIL unexpected_output: kind %0d got %0h, nothing expected", kind, act);
        end else begin
            e = exp_q.pop_front();
            checks <= checks + 1;
            if (kind == K_DRAIN) begin
                errors <= errors + 1;
                $display("[TB] FAIL %s: never observed, expected %0h", e.name, e.exp);
            end else if (e.kind != kind || e.exp != act) begin
                errors <= errors + 1;
                $display("[TB] FAIL %s: got %0h (kind %0d), expected %0h (kind %0d)",
                         e.name, act, kind, e.exp, e.kind);
            end
        end
    endtask

    always @(negedge clk) begin
        oe_prev <= ifc.D_OE;
        if (ifc.D_OE && !oe_prev)               scoreboard(K_READ, {24'd0, ifc.D_OUT});
        else if (pin_req)                       scoreboard(K_PIN, pins_now());
        else if (meas_req)                      scoreboard(K_MEAS, meas_val);
        else if (drain_req && exp_q.size() != 0) scoreboard(K_DRAIN, 0);
    end

    // Per-transfer SCLK statistics, cleared whenever the stimulus bumps xfer_id.
    int         xfer_id = 0, seen_id = 0;
    logic       sclk_prev = 1'b0;
    int         rises = 0, hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
    int         first_rise = 0, last_rise = 0, last_fall = 0;
    logic [7:0] mosi_bits = 8'h00;

    always @(negedge clk) begin
        if (seen_id != xfer_id) begin
            seen_id    <= xfer_id;
            rises      <= 0;
            hi_min     <= 1000;
            hi_max     <= 0;
            lo_min     <= 1000;
            lo_max     <= 0;
            first_rise <= 0;
            last_rise  <= 0;
            last_fall  <= 0;
            mosi_bits  <= 8'h00;
            sclk_prev  <= ifc.SCLK;
        end else if (ifc.SCLK != sclk_prev) begin
            sclk_prev <= ifc.SCLK;
            if (ifc.SCLK) begin
                rises     <= rises + 1;
                mosi_bits <= {mosi_bits[6:0], ifc.MOSI};
                last_rise <= cyc;
                if (rises == 0) begin
                    first_rise <= cyc;
                end else begin
                    lo_min <= ((cyc - last_fall) < lo_min) ? (cyc - last_fall) : lo_min;
                    lo_max <= ((cyc - last_fall) > lo_max) ? (cyc - last_fall) : lo_max;
                end
            end else begin
                last_fall <= cyc;
                hi_min    <= ((cyc - last_rise) < hi_min) ? (cyc - last_rise) : hi_min;
                hi_max    <= ((cyc - last_rise) > hi_max) ? (cyc - last_rise) : hi_max;
            end
        end
    end

    task automatic checkOutput(input int kind, input string name, input int exp);
        item_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // One full 6309 bus cycle; commit is the edge at which the write/read takes effect.
    task automatic applyStimulus(input logic rw, input logic [1:0] a, input logic [7:0] d,
                                 output int commit);
        @(posedge clk); #1;
        ifc.nSPICS = 1'b0;
        ifc.RW     = rw;
        ifc.A      = a;
        ifc.D_IN   = d;
        ifc.nE     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ifc.nE = 1'b1;
        commit = cyc + SYNC + 1;
        repeat (4) @(posedge clk);
        #1;
        ifc.nSPICS = 1'b1;
        ifc.RW     = 1'b1;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
        int c;
        applyStimulus(1'b0, a, d, c);
    endtask

    task automatic readReg(input logic [1:0] a, input logic [7:0] exp, input string name);
        int c;
        checkOutput(K_READ, name, {24'd0, exp});
        applyStimulus(1'b1, a, 8'h00, c);
    endtask

    task automatic checkPins(input string name, input logic [5:0] exp);
        checkOutput(K_PIN, name, {26'd0, exp});
        @(posedge clk); #1;
        pin_req = 1'b1;
        @(posedge clk); #1;
        pin_req = 1'b0;
    endtask

    task automatic checkMeas(input string name, input int act, input int exp);
        checkOutput(K_MEAS, name, exp);
        meas_val = act;
        @(posedge clk); #1;
        meas_req = 1'b1;
        @(posedge clk); #1;
        meas_req = 1'b0;
    endtask

    task automatic checkXfer(input string tag, input int commit, input int half,
                             input logic [7:0] bits);
        checkMeas({tag, "_rises"}, rises, 8);
        checkMeas({tag, "_hi_min"}, hi_min, half);
        checkMeas({tag, "_hi_max"}, hi_max, half);
        checkMeas({tag, "_lo_min"}, lo_min, half);
        checkMeas({tag, "_lo_max"}, lo_max, half);
        checkMeas({tag, "_first_rise"}, first_rise - commit, half);
        checkMeas({tag, "_busy_len"}, last_fall - commit, 16 * half);
        checkMeas({tag, "_mosi"}, {24'd0, mosi_bits}, {24'd0, bits});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Pin snapshot order: {SCLK, MOSI, nSD0, nSD1, nIRQ, D_OE}
    initial begin
        int         commit;
        logic [7:0] ctrl_exp;
        logic       nirq_exp;

        ifc.nE     = 1'b1;
        ifc.nSPICS = 1'b1;
        ifc.RW     = 1'b1;
        ifc.A      = 2'd0;
        ifc.D_IN   = 8'h00;

        repeat (3) @(posedge clk);
        checkPins("reset_pins", 6'b011110);
        @(posedge clk); #1;
        res = 1'b0;
        readReg(REG_DIV,    8'h3B, "reset_div");
        readReg(REG_DATA,   8'hFF, "reset_data");
        readReg(REG_STATUS, 8'h00, "reset_status");
        readReg(REG_CTRL,   8'h00, "reset_ctrl");

        $display("[TB] loopback transfer, DIV=0");
        loopback = 1'b1;
        writeReg(REG_DIV, 8'h00);
        writeReg(REG_CTRL, 8'h01);
        checkPins("sel0_pins", 6'b010110);
        xfer_id = xfer_id + 1;
        applyStimulus(1'b0, REG_DATA, 8'hA5, commit);
        repeat (40) @(posedge clk);
        #1;
        checkXfer("lb", commit, 1, 8'hA5);
        readReg(REG_STATUS, 8'h40, "lb_status");
        readReg(REG_DATA,   8'hA5, "lb_data");
        readReg(REG_STATUS, 8'h00, "lb_status_clr");

        $display("[TB] divider transfer, DIV=2, MISO=0");
        loopback = 1'b0;
        miso_val = 1'b0;
        writeReg(REG_DIV, 8'h02);
        xfer_id = xfer_id + 1;
        applyStimulus(1'b0, REG_DATA, 8'h3C, commit);
        repeat (70) @(posedge clk);
        #1;
        checkXfer("div", commit, 3, 8'h3C);
        readReg(REG_DATA, 8'h00, "div_data");

        $display("[TB] overrun");
        xfer_id = xfer_id + 1;
        applyStimulus(1'b0, REG_DATA, 8'h3C, commit);
        writeReg(REG_DATA, 8'hFF);
        readReg(REG_STATUS, 8'hA0, "ovr_status_busy");
        repeat (70) @(posedge clk);
        #1;
        checkMeas("ovr_rises", rises, 8);
        checkMeas("ovr_mosi", {24'd0, mosi_bits}, 32'h3C);
        checkMeas("ovr_busy_len", last_fall - commit, 48);
        readReg(REG_STATUS, 8'h60, "ovr_status_done");
        readReg(REG_DATA,   8'h00, "ovr_data");
        readReg(REG_STATUS, 8'h00, "ovr_status_clr");

        $display("[TB] select priority");
        writeReg(REG_CTRL, 8'h03);
        checkPins("sel_both", 6'b010110);
        writeReg(REG_CTRL, 8'h02);
        checkPins("sel1_only", 6'b011010);

        $display("[TB] abort by reset");
        writeReg(REG_CTRL, 8'h01);
        xfer_id = xfer_id + 1;
        applyStimulus(1'b0, REG_DATA, 8'hA5, commit);
        repeat (5) @(posedge clk);
        #1;
        res = 1'b1;
        checkPins("abort_pins", 6'b011110);
        @(posedge clk); #1;
        res = 1'b0;
        readReg(REG_DIV,    8'h3B, "abort_div");
        readReg(REG_STATUS, 8'h00, "abort_status");
        readReg(REG_DATA,   8'hFF, "abort_data");
        readReg(REG_CTRL,   8'h00, "abort_ctrl");

        $display("[TB] interrupt");
`ifdef KOLIBRI_SPI_IRQ_EN
        ctrl_exp = 8'h81;
        nirq_exp = 1'b0;
`else
        ctrl_exp = 8'h01;
        nirq_exp = 1'b1;
`endif
        loopback = 1'b1;
        writeReg(REG_DIV, 8'h00);
        writeReg(REG_CTRL, 8'h81);
        xfer_id = xfer_id + 1;
        applyStimulus(1'b0, REG_DATA, 8'h5A, commit);
        repeat (30) @(posedge clk);
        #1;
        readReg(REG_CTRL, ctrl_exp, "irq_ctrl");
        checkPins("irq_asserted", {4'b0101, nirq_exp, 1'b0});
        readReg(REG_DATA, 8'h5A, "irq_data");
        repeat (4) @(posedge clk);
        checkPins("irq_cleared", 6'b010110);

        drain_req = 1'b1;
        repeat (exp_q.size() + 3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
